// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DROP    = 2'd3
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // The reserved size code 11 is issued to memory as a word access.
    function automatic logic [1:0] legal_size(input logic [1:0] size);
        case (size)
            SIZE_BYTE, SIZE_HALF: return size;
            default:              return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Busy-cycle watchdog: counts cycles without ack and flags the cycle that hits the limit.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Combinational so an ack arriving in the limit cycle still takes precedence.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and load/store access to one single-port memory, data side first,
// one outstanding transaction, with flush-drop and timeout abort.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_if_req,
    input  logic [31:0] w_if_addr_32,
    output logic [31:0] w_if_rdata_32,
    output logic        w_if_valid,
    input  logic        w_dm_req,
    input  logic        w_dm_write,
    input  logic [1:0]  w_dm_size_2,
    input  logic [31:0] w_dm_addr_32,
    input  logic [31:0] w_dm_wdata_32,
    output logic [31:0] w_dm_rdata_32,
    output logic        w_dm_valid,
    input  logic        w_flush,
    output logic        w_stall_fetch,
    output logic        w_stall_data,
    output logic        w_mem_req,
    output logic        w_mem_write,
    output logic [1:0]  w_mem_size_2,
    output logic [31:0] w_mem_addr_32,
    output logic [31:0] w_mem_wdata_32,
    input  logic        w_mem_ack,
    input  logic [31:0] w_mem_rdata_32,
    output logic        w_timeout_err
);

    arb_state_t state, state_next;

    logic if_elig, dm_elig, busy;
    logic grant_if, grant_dm;
    logic if_done, dm_done, capture, abort;
    logic tmo_clear, tmo_en, tmo_expired;

    assign if_elig       = w_if_req & ~w_if_valid;
    assign dm_elig       = w_dm_req & ~w_dm_valid;
    assign w_stall_fetch = w_if_req & ~w_if_valid;
    assign w_stall_data  = w_dm_req & ~w_dm_valid;

    assign busy      = (state != IDLE);
    assign w_mem_req = busy;
    assign tmo_en    = busy & ~w_mem_ack;
    assign tmo_clear = (state_next != IDLE) && (state_next != state);

    mem_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_elig) begin
                    state_next = BUSY_DM;
                    grant_dm   = 1'b1;
                end else if (if_elig && !w_flush) begin
                    state_next = BUSY_IF;
                    grant_if   = 1'b1;
                end
            end
            BUSY_IF: begin
                if (w_mem_ack) begin
                    state_next = IDLE;
                    if_done    = ~w_flush;
                    capture    = ~w_flush;
                end else if (tmo_expired) begin
                    // A fetch flushed in its abort cycle is already dead; no pulse for it.
                    state_next = IDLE;
                    abort      = 1'b1;
                    if_done    = ~w_flush;
                end else if (w_flush) begin
                    state_next = DROP;
                end
            end
            BUSY_DM: begin
                if (w_mem_ack) begin
                    state_next = IDLE;
                    dm_done    = 1'b1;
                    capture    = ~w_mem_write;
                end else if (tmo_expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                    dm_done    = 1'b1;
                end
            end
            DROP: begin
                if (w_mem_ack) begin
                    state_next = IDLE;
                end else if (tmo_expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_mem_write    <= 1'b0;
            w_mem_size_2   <= '0;
            w_mem_addr_32  <= '0;
            w_mem_wdata_32 <= '0;
            w_if_rdata_32  <= '0;
            w_dm_rdata_32  <= '0;
            w_if_valid     <= 1'b0;
            w_dm_valid     <= 1'b0;
            w_timeout_err  <= 1'b0;
        end else begin
            w_if_valid <= if_done;
            w_dm_valid <= dm_done;
            if (abort) begin
                w_timeout_err <= 1'b1;
            end
            if (grant_dm) begin
                w_mem_write    <= w_dm_write;
                w_mem_size_2   <= legal_size(w_dm_size_2);
                w_mem_addr_32  <= w_dm_addr_32;
                w_mem_wdata_32 <= w_dm_wdata_32;
            end else if (grant_if) begin
                w_mem_write    <= 1'b0;
                w_mem_size_2   <= SIZE_WORD;
                w_mem_addr_32  <= w_if_addr_32;
                w_mem_wdata_32 <= '0;
            end
            if (if_done) begin
                w_if_rdata_32 <= capture ? w_mem_rdata_32 : '0;
            end
            // Completed stores leave the load data register untouched.
            if (dm_done && capture) begin
                w_dm_rdata_32 <= w_mem_rdata_32;
            end else if (dm_done && abort) begin
                w_dm_rdata_32 <= '0;
            end
        end
    end

endmodule
